cmp_pipe: RTL and testbench

Parametrised, two-stage pipelined comparator with valid/ready handshakes, signed/unsigned modes and six selectable relations. It also tracks a running maximum and minimum over all transferred results. It sits between the datapath and the IO/accelerator logic wherever a registered comparison, or a min/max over a stream of operand pairs, is needed.

---
 rtl/cmp_pipe.sv | 196 +++++++++++++++++++
 tb/tb_cmp_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator with valid/ready handshakes, signed/unsigned
// modes, six relations and a running max/min over all transferred results.
module cmp_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    input  logic                  sgn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_res,
    output logic                  out_lt,
    output logic                  out_eq,
    output logic                  out_gt,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_min,
    input  logic                  clr,
    output logic                  ext_valid,
    output logic [DATA_WIDTH-1:0] ext_max,
    output logic [DATA_WIDTH-1:0] ext_min,
    output logic [CNT_WIDTH-1:0]  ext_cnt
);

    localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Stage 1 holds operands already biased for signed mode.
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]            s1_op_q, s1_op_d;
    logic                  s1_sgn_q, s1_sgn_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_res_q, s2_res_d;
    logic                  s2_lt_q, s2_lt_d;
    logic                  s2_eq_q, s2_eq_d;
    logic                  s2_gt_q, s2_gt_d;
    logic [DATA_WIDTH-1:0] s2_max_q, s2_max_d;
    logic [DATA_WIDTH-1:0] s2_min_q, s2_min_d;
    logic                  s2_sgn_q, s2_sgn_d;

    logic                  ext_valid_q, ext_valid_d;
    logic [DATA_WIDTH-1:0] ext_max_q, ext_max_d;
    logic [DATA_WIDTH-1:0] ext_min_q, ext_min_d;
    logic [CNT_WIDTH-1:0]  ext_cnt_q, ext_cnt_d;

    logic                  s2_load;
    logic                  xfer;
    logic                  lt, eq, gt;
    logic [DATA_WIDTH-1:0] bias1, bias2;
    logic [DATA_WIDTH-1:0] a_raw, b_raw;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign xfer     = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sgn_d   = s1_sgn_q;
        bias1      = sgn ? MSB : '0;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_ready && in_valid) begin
            s1_a_d   = a ^ bias1;
            s1_b_d   = b ^ bias1;
            s1_op_d  = op;
            s1_sgn_d = sgn;
        end
    end

    always_comb begin
        lt    = s1_a_q < s1_b_q;
        eq    = s1_a_q == s1_b_q;
        gt    = s1_a_q > s1_b_q;
        bias2 = s1_sgn_q ? MSB : '0;
        a_raw = s1_a_q ^ bias2;
        b_raw = s1_b_q ^ bias2;

        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_lt_d    = s2_lt_q;
        s2_eq_d    = s2_eq_q;
        s2_gt_d    = s2_gt_q;
        s2_max_d   = s2_max_q;
        s2_min_d   = s2_min_q;
        s2_sgn_d   = s2_sgn_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load && s1_valid_q) begin
            case (s1_op_q)
                3'b000:  s2_res_d = gt;
                3'b001:  s2_res_d = gt || eq;
                3'b010:  s2_res_d = lt;
                3'b011:  s2_res_d = lt || eq;
                3'b100:  s2_res_d = eq;
                3'b101:  s2_res_d = !eq;
                default: s2_res_d = 1'b0;
            endcase
            s2_lt_d  = lt;
            s2_eq_d  = eq;
            s2_gt_d  = gt;
            s2_max_d = lt ? b_raw : a_raw;
            s2_min_d = gt ? b_raw : a_raw;
            s2_sgn_d = s1_sgn_q;
        end
    end

    // Extremum compare reuses the MSB bias with the result's own mode.
    logic [DATA_WIDTH-1:0] bias3;
    logic                  new_max, new_min;

    always_comb begin
        bias3       = s2_sgn_q ? MSB : '0;
        new_max     = (s2_max_q ^ bias3) > (ext_max_q ^ bias3);
        new_min     = (s2_min_q ^ bias3) < (ext_min_q ^ bias3);
        ext_valid_d = ext_valid_q;
        ext_max_d   = ext_max_q;
        ext_min_d   = ext_min_q;
        ext_cnt_d   = ext_cnt_q;
        if (clr) begin
            ext_valid_d = 1'b0;
            ext_max_d   = '0;
            ext_min_d   = '0;
            ext_cnt_d   = '0;
        end else if (xfer) begin
            ext_valid_d = 1'b1;
            if (!ext_valid_q || new_max) ext_max_d = s2_max_q;
            if (!ext_valid_q || new_min) ext_min_d = s2_min_q;
            if (!(&ext_cnt_q)) ext_cnt_d = ext_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_sgn_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= 1'b0;
            s2_lt_q     <= 1'b0;
            s2_eq_q     <= 1'b0;
            s2_gt_q     <= 1'b0;
            s2_max_q    <= '0;
            s2_min_q    <= '0;
            s2_sgn_q    <= 1'b0;
            ext_valid_q <= 1'b0;
            ext_max_q   <= '0;
            ext_min_q   <= '0;
            ext_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_sgn_q    <= s1_sgn_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_lt_q     <= s2_lt_d;
            s2_eq_q     <= s2_eq_d;
            s2_gt_q     <= s2_gt_d;
            s2_max_q    <= s2_max_d;
            s2_min_q    <= s2_min_d;
            s2_sgn_q    <= s2_sgn_d;
            ext_valid_q <= ext_valid_d;
            ext_max_q   <= ext_max_d;
            ext_min_q   <= ext_min_d;
            ext_cnt_q   <= ext_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_lt    = s2_lt_q;
    assign out_eq    = s2_eq_q;
    assign out_gt    = s2_gt_q;
    assign out_max   = s2_max_q;
    assign out_min   = s2_min_q;
    assign ext_valid = ext_valid_q;
    assign ext_max   = ext_max_q;
    assign ext_min   = ext_min_q;
    assign ext_cnt   = ext_cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed and random stimulus for cmp_pipe, checked against an arithmetic
// reference model of the relations, the FIFO order and the running extremum.
module tb_cmp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  op = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_res, out_lt, out_eq, out_gt;
    logic [31:0] out_max, out_min;
    logic        clr = 1'b0;
    logic        ext_valid;
    logic [31:0] ext_max, ext_min;
    logic [15:0] ext_cnt;

    cmp_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sgn(sgn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt),
        .out_max(out_max), .out_min(out_min),
        .clr(clr), .ext_valid(ext_valid),
        .ext_max(ext_max), .ext_min(ext_min), .ext_cnt(ext_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;
        logic [31:0] mx;
        logic [31:0] mn;
        logic        s;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          xfers = 0;
    bit          last_acc;
    bit          last_rdy;
    logic [3:0]  last_flags;
    logic [31:0] last_max, last_min;
    logic        m_ev;
    logic [31:0] m_max, m_min;
    logic [15:0] m_cnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint val(logic [31:0] x, logic s);
        return s ? longint'($signed(x)) : longint'({32'b0, x});
    endfunction

    function automatic exp_t model(logic [31:0] x, logic [31:0] y,
                                   logic [2:0] o, logic s);
        exp_t   e;
        longint vx, vy;
        logic   r;
        vx = val(x, s);
        vy = val(y, s);
        case (o)
            3'd0: r = vx > vy;
            3'd1: r = vx >= vy;
            3'd2: r = vx < vy;
            3'd3: r = vx <= vy;
            3'd4: r = vx == vy;
            3'd5: r = vx != vy;
            default: r = 1'b0;
        endcase
        e.flags = {r, vx < vy, vx == vy, vx > vy};
        e.mx = (vy > vx) ? y : x;
        e.mn = (vy < vx) ? y : x;
        e.s = s;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ev = 0; m_max = 0; m_min = 0; m_cnt = 0;
    endtask

    task automatic tick();
        bit   acc, xf;
        exp_t f, n;
        @(negedge clk);
        acc = in_valid && in_ready;
        xf = out_valid && out_ready;
        last_acc = acc;
        last_rdy = in_ready;
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (out_valid) begin
            chk("q_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                f = q[0];
                chk("flags", {out_res, out_lt, out_eq, out_gt}, f.flags);
                chk("out_max", out_max, f.mx);
                chk("out_min", out_min, f.mn);
            end
        end
        if (xf && q.size() != 0) begin
            f = q.pop_front();
            xfers++;
            last_flags = {out_res, out_lt, out_eq, out_gt};
            last_max = out_max;
            last_min = out_min;
            if (!clr) begin
                if (!m_ev || val(f.mx, f.s) > val(m_max, f.s)) m_max = f.mx;
                if (!m_ev || val(f.mn, f.s) < val(m_min, f.s)) m_min = f.mn;
                m_ev = 1;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
        end
        if (clr) begin
            m_ev = 0; m_max = 0; m_min = 0; m_cnt = 0;
        end
        if (acc) begin
            n = model(a, b, op, sgn);
            q.push_back(n);
        end
        @(posedge clk);
        #1;
        chk("ext_valid", ext_valid, m_ev);
        chk("ext_max", ext_max, m_max);
        chk("ext_min", ext_min, m_min);
        chk("ext_cnt", ext_cnt, m_cnt);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain_done", q.size(), 0);
    endtask

    task automatic send(logic [31:0] x, logic [31:0] y,
                        logic [2:0] o, logic s);
        a = x; b = y; op = o; sgn = s; in_valid = 1;
        last_acc = 0;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        chk("send_acc", last_acc, 1);
        in_valid = 0;
        drain();
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_pair();
        a = rval();
        b = ($urandom_range(0, 4) == 0) ? a : rval();
        op = 3'($urandom_range(0, 7));
        sgn = 1'($urandom_range(0, 1));
    endtask

    logic [7:0]  opexp;
    logic [3:0]  hold_flags;
    logic [31:0] hold_max, hold_min;
    int          base;

    initial begin
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flags", {out_res, out_lt, out_eq, out_gt}, 0);
        chk("rst_max_min", {out_max, out_min}, 0);
        chk("rst_ext", {ext_valid, ext_max, ext_min, ext_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 0;

        send(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b0);
        chk("u_gt_flags", last_flags, 4'b1001);
        chk("u_gt_max", last_max, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b1);
        chk("s_gt_flags", last_flags, 4'b0100);
        chk("s_gt_max", last_max, 32'h1);
        chk("s_gt_min", last_min, 32'hFFFF_FFFF);

        opexp = 8'b0001_1010;
        for (int o = 0; o < 8; o++) begin
            send(32'h1234_5678, 32'h1234_5678, 3'(o), 1'b0);
            chk("eq_res", last_flags[3], opexp[o]);
            chk("eq_flag", last_flags[2:0], 3'b010);
            chk("eq_maxmin", {last_max, last_min},
                {32'h1234_5678, 32'h1234_5678});
        end

        out_ready = 1;
        base = xfers;
        for (int i = 0; i < 8; i++) begin
            rand_pair();
            in_valid = 1;
            tick();
            chk("stream_rdy", last_rdy, 1);
            if (i == 0) chk("lat_first", out_valid, 0);
            if (i == 1) chk("lat_second", out_valid, 1);
        end
        in_valid = 0;
        tick();
        tick();
        chk("stream_cnt", xfers - base, 8);
        chk("stream_empty", q.size(), 0);

        out_ready = 0;
        rand_pair();
        in_valid = 1;
        for (int i = 0; i < 5 && in_ready; i++) begin
            tick();
            if (last_acc) rand_pair();
        end
        chk("full_rdy", in_ready, 0);
        chk("full_q", q.size(), 2);
        hold_flags = {out_res, out_lt, out_eq, out_gt};
        hold_max = out_max;
        hold_min = out_min;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rdy", last_rdy, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_flags", {out_res, out_lt, out_eq, out_gt}, hold_flags);
            chk("hold_mm", {out_max, out_min}, {hold_max, hold_min});
        end
        in_valid = 0;
        out_ready = 1;
        base = xfers;
        tick();
        chk("drain1_valid", out_valid, 1);
        tick();
        chk("drain2_valid", out_valid, 0);
        chk("drain_cnt", xfers - base, 2);

        clr = 1;
        tick();
        clr = 0;
        send(32'd3, -32'sd7, 3'd0, 1'b1);
        send(32'd10, 32'd2, 3'd1, 1'b1);
        send(-32'sd20, 32'd0, 3'd2, 1'b1);
        chk("ext3_max", ext_max, 32'd10);
        chk("ext3_min", ext_min, 32'hFFFF_FFEC);
        chk("ext3_cnt", ext_cnt, 3);
        out_ready = 0;
        a = 32'd100; b = 32'd5; op = 3'd0; sgn = 1;
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 5 && !out_valid; i++) tick();
        chk("ext4_valid", out_valid, 1);
        out_ready = 1;
        clr = 1;
        tick();
        clr = 0;
        chk("clr_ev", ext_valid, 0);
        chk("clr_cnt", ext_cnt, 0);

        for (int i = 0; i < 300; i++) begin
            rand_pair();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 60) == 0);
            tick();
        end
        clr = 0;
        in_valid = 0;
        drain();

        send(32'd1, 32'd2, 3'd2, 1'b0);
        out_ready = 0;
        rand_pair();
        in_valid = 1;
        for (int i = 0; i < 5 && in_ready; i++) begin
            tick();
            if (last_acc) rand_pair();
        end
        chk("pre_rst_full", q.size(), 2);
        chk("pre_rst_ev", ext_valid, 1);
        rst = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ext", {ext_valid, ext_max, ext_min, ext_cnt}, 0);
        chk("arst_rdy", in_ready, 1);
        model_reset();
        in_valid = 0;
        out_ready = 1;
        #1;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
